// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet transmit arbiter.
package eth_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        GAP      = 2'd3
    } eth_state_e;

    localparam int unsigned PREAMBLE_DIBITS    = 32;
    localparam logic [1:0]  PREAMBLE_DIBIT     = 2'b01;
    localparam logic [1:0]  SFD_DIBIT          = 2'b11;
    localparam int unsigned IFG_DIBITS_DEFAULT = 48;
    localparam int unsigned PAY_CNT_W          = 13;
    localparam int unsigned TMR_W              = 16;

endpackage

// File: rtl/eth_tx_arbiter_if.sv
// Requester/transmit bundle between two frame sources and the arbiter.
interface eth_tx_arbiter_if;
    logic [1:0] req;
    logic       src0_axiiv;
    logic [1:0] src0_axiid;
    logic       src1_axiiv;
    logic [1:0] src1_axiid;
    logic [1:0] gnt;
    logic       axiov;
    logic [1:0] axiod;
    logic       busy;
    logic       err;

    // Requester side drives requests and dibits.
    modport master (
        output req, src0_axiiv, src0_axiid, src1_axiiv, src1_axiid,
        input  gnt, axiov, axiod, busy, err
    );

    // Arbiter side.
    modport slave (
        input  req, src0_axiiv, src0_axiid, src1_axiiv, src1_axiid,
        output gnt, axiov, axiod, busy, err
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: single request wins, ties go to the one not served last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] win
);

    // One-hot winner; zero when nobody requests.
    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = last ? 2'b01 : 2'b10;
            default: win = 2'b00;
        endcase
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Arbitrates two frame sources onto one RMII dibit stream: preamble+SFD, payload, inter-frame gap.
module eth_tx_arbiter
    import eth_pkg::*;
#(
    parameter int unsigned IFG_DIBITS = IFG_DIBITS_DEFAULT,
    parameter int unsigned MAX_DIBITS = 6072
) (
    input logic              clk,
    input logic              rst,
    eth_tx_arbiter_if.slave  bus
);

    localparam logic [TMR_W-1:0]     PRE_LAST = TMR_W'(PREAMBLE_DIBITS - 2);
    localparam logic [TMR_W-1:0]     IFG_LAST = TMR_W'(IFG_DIBITS - 1);
    localparam logic [PAY_CNT_W-1:0] MAX_LAST = PAY_CNT_W'(MAX_DIBITS - 1);

    eth_state_e           state_q, state_d;
    logic [1:0]           gnt_q, gnt_d;
    logic                 axiov_q, axiov_d;
    logic [1:0]           axiod_q, axiod_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic                 win_q, win_d;
    logic                 last_q, last_d;
    logic [PAY_CNT_W-1:0] cnt_q, cnt_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic [1:0]           sel;
    logic                 src_v;
    logic [1:0]           src_d;

    rr_arb2 u_rr_arb2 (
        .req  (bus.req),
        .last (last_q),
        .win  (sel)
    );

    // Only the current winner's stream is visible to the datapath.
    always_comb begin
        src_v = win_q ? bus.src1_axiiv : bus.src0_axiiv;
        src_d = win_q ? bus.src1_axiid : bus.src0_axiid;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        axiov_d = 1'b0;
        axiod_d = 2'b00;
        err_d   = 1'b0;
        win_d   = win_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        unique case (state_q)
            IDLE: begin
                if (sel != 2'b00) begin
                    state_d = PREAMBLE;
                    win_d   = sel[1];
                    last_d  = sel[1];
                    cnt_d   = '0;
                    tmr_d   = '0;
                    axiov_d = 1'b1;
                    axiod_d = PREAMBLE_DIBIT;
                end
            end
            PREAMBLE, DATA: begin
                if (gnt_q == 2'b00) begin
                    // Preamble body; grant rises together with the SFD dibit.
                    tmr_d   = tmr_q + TMR_W'(1);
                    axiov_d = 1'b1;
                    if (tmr_q == PRE_LAST) begin
                        axiod_d = SFD_DIBIT;
                        gnt_d   = win_q ? 2'b10 : 2'b01;
                    end else begin
                        axiod_d = PREAMBLE_DIBIT;
                    end
                end else if (src_v) begin
                    axiov_d = 1'b1;
                    axiod_d = src_d;
                    state_d = DATA;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + PAY_CNT_W'(1);
                    end
                    if (cnt_q == MAX_LAST) begin
                        gnt_d   = 2'b00;
                        err_d   = 1'b1;
                        state_d = GAP;
                        tmr_d   = '0;
                    end
                end else begin
                    gnt_d   = 2'b00;
                    err_d   = (cnt_q == '0);
                    state_d = GAP;
                    tmr_d   = '0;
                end
            end
            GAP: begin
                // Count only silent cycles so an oversize tail dibit does not eat into the gap.
                if (!axiov_q) begin
                    if (tmr_q == IFG_LAST) begin
                        state_d = IDLE;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            axiov_q <= 1'b0;
            axiod_q <= 2'b00;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            win_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            axiov_q <= axiov_d;
            axiod_q <= axiod_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            win_q   <= win_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.axiov = axiov_q;
    assign bus.axiod = axiod_q;
    assign bus.busy  = busy_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench for eth_tx_arbiter: frame table plus a reset-mid-frame sequence.
module tb_eth_tx_arbiter;

    localparam int IFG = 48;
    localparam int MAXD = 16;

    typedef struct {
        logic [1:0] rq;
        bit         win;
        int         n;
        bit         drop;
        bit         fixed;
        int         exp_err;
        int         exp_pay;
    } vec_t;

    logic clk;
    logic rst;
    eth_tx_arbiter_if bus ();

    eth_tx_arbiter #(
        .IFG_DIBITS (IFG),
        .MAX_DIBITS (MAXD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int ov_cnt = 0;
    int err_cnt = 0;
    bit sb_en = 1'b1;
    logic [1:0] exp_q[$];
    vec_t vecs[7];

    task automatic chk_eq(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] dat(input vec_t v, input int i);
        int t;
        t = i * 3 + 1;
        return v.fixed ? 2'b10 : t[1:0];
    endfunction

    task automatic drive_src(input bit w, input logic vv, input logic [1:0] dd);
        if (w) begin
            bus.src1_axiiv = vv;
            bus.src1_axiid = vv ? dd : 2'b00;
        end else begin
            bus.src0_axiiv = vv;
            bus.src0_axiid = vv ? dd : 2'b00;
        end
    endtask

    // Output monitor: scoreboard pop, one-cycle latency check, idle-zero check.
    initial begin
        logic       prev_acc;
        logic [1:0] prev_dat;
        logic [1:0] e;
        prev_acc = 1'b0;
        prev_dat = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_acc = 1'b0;
            end else begin
                if (prev_acc) begin
                    chk_eq("latency_valid", int'(bus.axiov), 1);
                    chk_eq("latency_data", int'(bus.axiod), int'(prev_dat));
                end
                if (!bus.axiov) chk_eq("idle_axiod_zero", int'(bus.axiod), 0);
                chk_eq("gnt_not_both", int'(bus.gnt == 2'b11), 0);
                if (bus.axiov) begin
                    ov_cnt++;
                    if (sb_en) begin
                        chk_eq("sb_nonempty", int'(exp_q.size() != 0), 1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            chk_eq("sb_axiod", int'(bus.axiod), int'(e));
                        end
                    end
                end
                if (bus.err) err_cnt++;
                prev_acc = (bus.gnt[0] && bus.src0_axiiv) || (bus.gnt[1] && bus.src1_axiiv);
                prev_dat = bus.gnt[1] ? bus.src1_axiid : bus.src0_axiid;
            end
        end
    end

    // Runs one frame from request to the end of its gap; returns on the first IDLE cycle.
    task automatic run_frame(input vec_t v);
        int phase, idx, cyc, gap, ov0, er0;
        bit done, acc;
        logic cur_v;
        logic [1:0] cur_d;
        ov0 = ov_cnt;
        er0 = err_cnt;
        for (int i = 0; i < 31; i++) exp_q.push_back(2'b01);
        exp_q.push_back(2'b11);
        phase = 0; idx = 0; cyc = 0; gap = 0; done = 1'b0;
        cur_v = (v.n > 0);
        cur_d = dat(v, 0);
        bus.req = v.rq;
        drive_src(v.win, cur_v, cur_d);
        while (!done) begin
            @(negedge clk);
            #2;
            cyc++;
            acc = 1'b0;
            if (cyc > 400) begin
                chk_eq("frame_timeout", cyc, 400);
                exp_q.delete();
                done = 1'b1;
            end else begin
                if (phase == 0 && bus.gnt != 2'b00) begin
                    phase = 1;
                    chk_eq("grant_onehot", int'(bus.gnt), v.win ? 2 : 1);
                    chk_eq("sfd_at_grant", int'(bus.axiod), 3);
                end
                if (phase == 1) begin
                    if (bus.gnt == 2'b00) begin
                        phase = 2;
                    end else if (cur_v) begin
                        acc = 1'b1;
                        exp_q.push_back(cur_d);
                        idx++;
                    end
                end
                if (phase == 2) begin
                    if (!bus.busy) done = 1'b1;
                    else if (!bus.axiov) gap++;
                end
            end
            if (!done) begin
                @(posedge clk);
                #1;
                if (phase >= 1 && v.drop) bus.req = 2'b00;
                if (phase == 2) begin
                    cur_v = 1'b0;
                end else if (acc) begin
                    cur_v = (idx < v.n);
                    cur_d = dat(v, idx);
                end
                drive_src(v.win, cur_v, cur_d);
                // Noise on the losing source must never reach the output.
                drive_src(!v.win, logic'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            end
        end
        chk_eq("payload_accepted", idx, v.exp_pay);
        chk_eq("axiov_cycles", ov_cnt - ov0, 32 + v.exp_pay);
        chk_eq("err_pulses", err_cnt - er0, v.exp_err);
        chk_eq("ifg_cycles", gap, IFG);
        chk_eq("sb_drained", exp_q.size(), 0);
    endtask

    initial begin
        int cyc;
        vec_t rv;
        vecs[0] = '{rq: 2'b11, win: 1'b0, n: 4, drop: 1'b0, fixed: 1'b0, exp_err: 0, exp_pay: 4};
        vecs[1] = '{rq: 2'b11, win: 1'b1, n: 4, drop: 1'b0, fixed: 1'b0, exp_err: 0, exp_pay: 4};
        vecs[2] = '{rq: 2'b11, win: 1'b0, n: 4, drop: 1'b0, fixed: 1'b0, exp_err: 0, exp_pay: 4};
        vecs[3] = '{rq: 2'b11, win: 1'b1, n: 4, drop: 1'b1, fixed: 1'b0, exp_err: 0, exp_pay: 4};
        vecs[4] = '{rq: 2'b01, win: 1'b0, n: 8, drop: 1'b1, fixed: 1'b1, exp_err: 0, exp_pay: 8};
        vecs[5] = '{rq: 2'b10, win: 1'b1, n: 0, drop: 1'b1, fixed: 1'b0, exp_err: 1, exp_pay: 0};
        vecs[6] = '{rq: 2'b01, win: 1'b0, n: 40, drop: 1'b1, fixed: 1'b0, exp_err: 1, exp_pay: MAXD};

        rst = 1'b0;
        bus.req = 2'b00;
        drive_src(1'b0, 1'b0, 2'b00);
        drive_src(1'b1, 1'b0, 2'b00);
        repeat (3) @(negedge clk);
        #2;
        chk_eq("rst_gnt", int'(bus.gnt), 0);
        chk_eq("rst_axiov", int'(bus.axiov), 0);
        chk_eq("rst_axiod", int'(bus.axiod), 0);
        chk_eq("rst_busy", int'(bus.busy), 0);
        chk_eq("rst_err", int'(bus.err), 0);
        rst = 1'b1;
        @(negedge clk);
        #2;

        for (int r = 0; r < 7; r++) run_frame(vecs[r]);

        // Reset while payload dibit 5 is on the wire.
        sb_en = 1'b0;
        bus.req = 2'b01;
        drive_src(1'b0, 1'b1, 2'b10);
        cyc = 0;
        while (bus.gnt == 2'b00 && cyc < 100) begin
            @(negedge clk);
            #2;
            cyc++;
        end
        chk_eq("rstseq_grant", int'(bus.gnt), 1);
        repeat (5) begin
            @(negedge clk);
            #2;
        end
        chk_eq("rstseq_axiov_before", int'(bus.axiov), 1);
        rst = 1'b0;
        #1;
        chk_eq("rstseq_gnt", int'(bus.gnt), 0);
        chk_eq("rstseq_axiov", int'(bus.axiov), 0);
        chk_eq("rstseq_axiod", int'(bus.axiod), 0);
        chk_eq("rstseq_busy", int'(bus.busy), 0);
        bus.req = 2'b00;
        drive_src(1'b0, 1'b0, 2'b00);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        sb_en = 1'b1;
        rv = '{rq: 2'b01, win: 1'b0, n: 6, drop: 1'b1, fixed: 1'b0, exp_err: 0, exp_pay: 6};
        run_frame(rv);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eth_tx_arbiter.md
ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

Interface
REQ-001 Parameter IFG_DIBITS, default 48, inter-frame gap length in clock cycles (12 bytes).
REQ-002 Parameter MAX_DIBITS, default 6072, maximum payload dibits accepted per frame (1518 bytes).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req  input  2  per-requester frame request; bit i belongs to requester i.
REQ-006 src0_axiiv / src1_axiiv  input  1 each  requester dibit valid.
REQ-007 src0_axiid / src1_axiid  input  2 each  requester dibit, LSB-first wire order.
REQ-008 gnt  output  2  one-hot grant; a requester's dibit is accepted on every edge where its gnt bit and axiiv are both high.
REQ-009 axiov  output  1  transmit dibit valid toward the RMII TX pin driver.
REQ-010 axiod  output  2  transmit dibit.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 err  output  1  one-cycle pulse on an oversize or empty frame.

Function
REQ-013 FSM states: IDLE, PREAMBLE, DATA, GAP.
REQ-014 IDLE: when any req bit is high, the FSM selects the winner and enters PREAMBLE on the next edge.
REQ-015 Winner selection: a single request wins; on simultaneous requests, the requester not served last wins; the last-served pointer resets to 1, so requester 0 wins first.
REQ-016 PREAMBLE: axiov high for exactly 32 cycles; axiod 2'b01 for the first 31 cycles and SFD 2'b11 on the 32nd.
REQ-017 gnt[winner] rises in the cycle axiod shows 2'b11; the other gnt bit stays 0 throughout.
REQ-018 DATA: a dibit accepted at edge k appears on axiod with axiov high in cycle k+1, giving a fixed latency of one cycle.
REQ-019 Output during DATA is gap-free while the requester keeps axiiv high.
REQ-020 End of frame: the first gnt-high cycle with the winner's axiiv low ends DATA. On that edge gnt clears, axiov is 0 next cycle, and the FSM enters GAP.
REQ-021 Empty frame: if zero dibits were accepted before end of frame, err pulses once; the frame is still closed via GAP.
REQ-022 Oversize frame: on the edge that accepts dibit number MAX_DIBITS, gnt clears, err pulses next cycle, and the FSM enters GAP. The requester drops the remainder of its frame.
REQ-023 GAP: axiov 0 and axiod 2'b00 for exactly IFG_DIBITS cycles, then IDLE; requests are ignored during GAP.
REQ-024 The FSM enters IDLE only from GAP, so back-to-back frames are always separated by IFG_DIBITS cycles.
REQ-025 Whenever axiov is 0, axiod is 2'b00.
REQ-026 Deassertion of req after selection does not abort the sequence; only axiiv controls frame end.
REQ-027 Input change on the non-granted source is ignored.
REQ-028 Payload counter: 13-bit width, saturating; it clears on entry to PREAMBLE.
REQ-029 All outputs are registered.

Reset
REQ-030 While rst is low: gnt=2'b00, axiov=0, axiod=2'b00, busy=0, err=0, state IDLE, counters 0, last-served pointer=1.
REQ-031 Reset asserted mid-frame forces these values asynchronously, with no gap enforced afterward.
REQ-032 After reset release, the first edge with req high starts a new PREAMBLE.

Structure
REQ-033 Package eth_pkg holds: the FSM state enum, PREAMBLE_DIBITS=32, PREAMBLE_DIBIT=2'b01, SFD_DIBIT=2'b11, and the default IFG_DIBITS.
REQ-034 Sub-module rr_arb2 is the two-way round-robin selector; its inputs are req and the last-served pointer, and its outputs are the one-hot winner.

Verification
REQ-035 Single frame: req=2'b01, src0 sends 8 dibits 2'b10 → 31x01, 1x11, 8x10 on axiod contiguous, then 48 idle cycles; err never pulses.
REQ-036 Contention: req=2'b11 held, each sends 4 dibits → grant order 0,1,0,1; each frame is preceded by a preamble; at least 48 cycles between frames.
REQ-037 Empty frame: req=2'b10, src1_axiiv low at grant → 32 preamble dibits, err pulse, GAP of 48 cycles.
REQ-038 Oversize: MAX_DIBITS=16, src0 streams 40 dibits → exactly 16 payload dibits out, gnt low after the 16th, single err pulse.
REQ-039 Reset mid-DATA: rst low at payload dibit 5 → axiov=0, gnt=0 in the same cycle; after release req=2'b01 → fresh 32-dibit preamble.
REQ-040 Latency check: every accepted dibit is compared against axiod exactly one cycle later; axiod=2'b00 whenever axiov=0.
